// File: rtl/field_frame_scheduler_pkg.sv
// Shared types and default sizing for the field/score frame scheduler.
// The defaults describe a 20x20 play field with a 32-bit score.
package field_sched_pkg;

  localparam int DEF_ROWS        = 20;
  localparam int DEF_ROW_W       = 20;
  localparam int DEF_SCORE_W     = 32;
  localparam int DEF_FRAME_CNT_W = 16;
  localparam int DEF_FIELD_W     = DEF_ROWS * DEF_ROW_W;
  localparam int DEF_ROW_IDX_W   = $clog2(DEF_ROWS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_COPY    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Row-index width that still works for a single-row field.
  function automatic int row_idx_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/field_frame_scheduler_if.sv
// Request side of the scheduler: level request with field/score payload and
// the four-phase acknowledge returned by the scheduler.
interface field_frame_scheduler_if
  import field_sched_pkg::*;
#(
  parameter int FIELD_W = DEF_FIELD_W,
  parameter int SCORE_W = DEF_SCORE_W
) ();

  logic               iReq;
  logic [FIELD_W-1:0] iField;
  logic [SCORE_W-1:0] iScore;
  logic               oAck;
  logic               oBusy;

  modport master (output iReq, iField, iScore, input oAck, oBusy);
  modport slave  (input iReq, iField, iScore, output oAck, oBusy);

endinterface

// File: rtl/field_frame_scheduler_vsync_edge_detect.sv
// Start-of-vsync detector: one-cycle pulse on the falling edge of the
// active-low vsync. Also used by the score-flash logic.
module vsync_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vs,
  output logic o_vs_start
);

  logic r_vs_d;

  // Delayed vsync; resets high so reset release never looks like an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_vs_d <= 1'b1;
    else          r_vs_d <= i_vs;
  end

  assign o_vs_start = r_vs_d & ~i_vs;

endmodule

// File: rtl/field_frame_scheduler.sv
// Tear-free field/score handoff to the VGA pixel path. A request is parked
// until the start of vsync, then the field is copied one row per cycle into
// the display shadow, the score is latched with the last row and the request
// is acknowledged.
// Optional macro FIELD_SCHED_TIMEOUT_EN: watchdog that forces the copy after
// TIMEOUT_CYC cycles in PENDING and raises a sticky oTimeout.
//
// state   | meaning
// IDLE    | no request outstanding
// PENDING | request seen, waiting for start of vsync
// COPY    | copying one row per cycle into the shadow
// DONE    | ack high, waiting for request to drop
module field_frame_scheduler
  import field_sched_pkg::*;
#(
  parameter int ROWS        = DEF_ROWS,
  parameter int ROW_W       = DEF_ROW_W,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int FRAME_CNT_W = DEF_FRAME_CNT_W,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                   iVGA_CLK,
  input  logic                   iRST_n,
  input  logic                   iVS,
  field_frame_scheduler_if.slave bus,
  output logic [ROWS*ROW_W-1:0]  oField,
  output logic [SCORE_W-1:0]     oScore,
  output logic [FRAME_CNT_W-1:0] oFrameCnt,
  output logic                   oTimeout
);

  localparam int FIELD_W = ROWS * ROW_W;
  localparam int IDX_W   = row_idx_w(ROWS);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [FIELD_W-1:0]   r_field;
  logic [SCORE_W-1:0]   r_score;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                 w_vs_start;
  logic                 w_copy_last;
  logic                 w_to_hit;

  vsync_edge_detect u_vs_edge (
    .i_clk      (iVGA_CLK),
    .i_rst_n    (iRST_n),
    .i_vs       (iVS),
    .o_vs_start (w_vs_start)
  );

  assign w_copy_last = (r_idx == IDX_W'(ROWS - 1));

`ifdef FIELD_SCHED_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  assign w_to_hit = (r_state == S_PENDING) && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Cycles spent in PENDING; cleared whenever PENDING is left.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n)                                              r_to_cnt <= '0;
    else if (r_state == S_PENDING && w_state_nxt == S_PENDING) r_to_cnt <= r_to_cnt + 1'b1;
    else                                                      r_to_cnt <= '0;
  end

  // Sticky flag: set only when the watchdog, not vsync, started the copy.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n)                                    r_timeout <= 1'b0;
    else if (w_to_hit && bus.iReq && !w_vs_start)   r_timeout <= 1'b1;
  end

  assign oTimeout = r_timeout;
`else
  assign w_to_hit = 1'b0;
  assign oTimeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode; iReq is deliberately ignored while copying.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.iReq) w_state_nxt = w_vs_start ? S_COPY : S_PENDING;
      end
      S_PENDING: begin
        if (!bus.iReq)                   w_state_nxt = S_IDLE;
        else if (w_vs_start || w_to_hit) w_state_nxt = S_COPY;
      end
      S_COPY: begin
        if (w_copy_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!bus.iReq) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Row index walks 0..ROWS-1 during COPY and sits at 0 otherwise.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n)                              r_idx <= '0;
    else if (r_state == S_COPY && !w_copy_last) r_idx <= r_idx + 1'b1;
    else                                      r_idx <= '0;
  end

  // Display shadow: written only in COPY, score with the final row.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_field <= '0;
      r_score <= '0;
    end else if (r_state == S_COPY) begin
      for (int r = 0; r < ROWS; r++) begin
        if (r_idx == IDX_W'(r)) r_field[r*ROW_W +: ROW_W] <= bus.iField[r*ROW_W +: ROW_W];
      end
      if (w_copy_last) r_score <= bus.iScore;
    end
  end

  // Frame counter counts every vsync start regardless of state.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n)         r_frame_cnt <= '0;
    else if (w_vs_start) r_frame_cnt <= r_frame_cnt + 1'b1;
  end

  assign bus.oAck  = (r_state == S_DONE);
  assign bus.oBusy = (r_state == S_PENDING) || (r_state == S_COPY);
  assign oField    = r_field;
  assign oScore    = r_score;
  assign oFrameCnt = r_frame_cnt;

endmodule

// File: tb/tb_field_frame_scheduler.sv
// Self-checking bench for field_frame_scheduler with a row-level model of the
// tear-free copy: after vsync the shadow gains one new row per cycle and the
// ack appears 21 cycles after vsync falls.
module tb_field_frame_scheduler;
  import field_sched_pkg::*;

  localparam int TO_CYC = 1000;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       vs = 1'b1;
  logic [DEF_FIELD_W-1:0]     o_field;
  logic [DEF_SCORE_W-1:0]     o_score;
  logic [DEF_FRAME_CNT_W-1:0] o_fc;
  logic                       o_to;

  field_frame_scheduler_if #(.FIELD_W(DEF_FIELD_W), .SCORE_W(DEF_SCORE_W)) bus ();

  field_frame_scheduler #(.TIMEOUT_CYC(TO_CYC)) dut (
    .iVGA_CLK  (clk),
    .iRST_n    (rst_n),
    .iVS       (vs),
    .bus       (bus),
    .oField    (o_field),
    .oScore    (o_score),
    .oFrameCnt (o_fc),
    .oTimeout  (o_to)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DEF_FIELD_W-1:0] exp_field = '0;
  logic [DEF_SCORE_W-1:0] exp_score = '0;
  int                     exp_frames = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DEF_FIELD_W-1:0] rand_field();
    logic [DEF_FIELD_W-1:0] f;
    for (int r = 0; r < DEF_ROWS; r++) f[r*DEF_ROW_W +: DEF_ROW_W] = DEF_ROW_W'($urandom);
    return f;
  endfunction

  // First n rows from the new field, the rest from the old one.
  function automatic logic [DEF_FIELD_W-1:0] merge(input logic [DEF_FIELD_W-1:0] old_f,
                                                   input logic [DEF_FIELD_W-1:0] new_f,
                                                   input int n);
    logic [DEF_FIELD_W-1:0] res;
    for (int r = 0; r < DEF_ROWS; r++)
      res[r*DEF_ROW_W +: DEF_ROW_W] = (r < n) ? new_f[r*DEF_ROW_W +: DEF_ROW_W]
                                              : old_f[r*DEF_ROW_W +: DEF_ROW_W];
    return res;
  endfunction

  // One full transaction: request held 'lead' cycles before vsync falls,
  // optional extra vsync at cycle extra_vs_m after the fall (COPY or DONE).
  task automatic run_request(input logic [DEF_FIELD_W-1:0] f, input logic [DEF_SCORE_W-1:0] s,
                             input int lead, input int extra_vs_m, input string tag);
    int ack_m;
    int rows;
    logic [DEF_FIELD_W-1:0] ef;
    bus.iReq = 1'b1; bus.iField = f; bus.iScore = s;
    for (int i = 0; i < lead; i++) begin
      tick();
      checks++;
      if (bus.oBusy !== 1'b1 || bus.oAck !== 1'b0 || o_field !== exp_field) begin
        errors++;
        $display("FAIL %s pending busy=%b ack=%b want busy=1 ack=0 field_changed=%b",
                 tag, bus.oBusy, bus.oAck, o_field !== exp_field);
      end
    end
    vs = 1'b0; exp_frames++;
    ack_m = -1;
    for (int m = 1; m <= 30; m++) begin
      if (m == 3) vs = 1'b1;
      if (extra_vs_m != 0 && m == extra_vs_m) begin vs = 1'b0; exp_frames++; end
      if (extra_vs_m != 0 && m == extra_vs_m + 1) vs = 1'b1;
      tick();
      rows = (m - 1 > DEF_ROWS) ? DEF_ROWS : m - 1;
      ef = merge(exp_field, f, rows);
      checks++;
      if (o_field !== ef) begin
        errors++;
        $display("FAIL %s copy_rows m=%0d got %h want %h", tag, m, o_field, ef);
      end
      checks++;
      if (bus.oAck !== (m >= 21) || bus.oBusy !== (m < 21) || o_score !== ((m >= 21) ? s : exp_score)) begin
        errors++;
        $display("FAIL %s ctl m=%0d ack=%b busy=%b score=%0d want ack=%b busy=%b score=%0d",
                 tag, m, bus.oAck, bus.oBusy, o_score, m >= 21, m < 21, (m >= 21) ? s : exp_score);
      end
      if (bus.oAck === 1'b1 && ack_m < 0) ack_m = m;
    end
    checks++;
    if (ack_m != 21) begin
      errors++;
      $display("FAIL %s ack_latency got %0d want 21", tag, ack_m);
    end
    exp_field = f; exp_score = s;
    bus.iReq = 1'b0;
    tick();
    checks++;
    if (bus.oAck !== 1'b0 || bus.oBusy !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_drop ack=%b busy=%b want 0 0", tag, bus.oAck, bus.oBusy);
    end
    checks++;
    if (o_fc !== DEF_FRAME_CNT_W'(exp_frames)) begin
      errors++;
      $display("FAIL %s frame_cnt got %0d want %0d", tag, o_fc, exp_frames);
    end
  endtask

  task automatic test_reset();
    bus.iReq = 1'b0; bus.iField = '0; bus.iScore = '0;
    rst_n = 1'b0; vs = 1'b1;
    repeat (3) tick();
    checks++;
    if (o_field !== '0 || o_score !== '0 || bus.oAck !== 1'b0 || bus.oBusy !== 1'b0 ||
        o_fc !== '0 || o_to !== 1'b0) begin
      errors++;
      $display("FAIL reset_state score=%0d ack=%b busy=%b fc=%0d to=%b want all 0",
               o_score, bus.oAck, bus.oBusy, o_fc, o_to);
    end
    rst_n = 1'b1;
    tick();
    for (int fr = 0; fr < 2; fr++) begin
      repeat (40) tick();
      vs = 1'b0; exp_frames++;
      repeat (2) tick();
      vs = 1'b1;
    end
    repeat (5) tick();
    checks++;
    if (o_fc !== 16'd2 || o_field !== '0 || o_score !== '0 || bus.oAck !== 1'b0) begin
      errors++;
      $display("FAIL idle_frames fc=%0d score=%0d ack=%b want fc=2 score=0 ack=0",
               o_fc, o_score, bus.oAck);
    end
  endtask

  task automatic test_basic_copy();
    logic [DEF_FIELD_W-1:0] f;
    for (int r = 0; r < DEF_ROWS; r++) f[r*DEF_ROW_W +: DEF_ROW_W] = 20'hAAAAA;
    run_request(f, 32'd123, 10, 0, "basic");
  endtask

  task automatic test_same_cycle();
    run_request(rand_field(), $urandom, 0, 0, "same_cycle");
  endtask

  task automatic test_abort();
    bus.iReq = 1'b1; bus.iField = rand_field(); bus.iScore = $urandom;
    repeat ($urandom_range(3, 10)) tick();
    checks++;
    if (bus.oBusy !== 1'b1 || bus.oAck !== 1'b0) begin
      errors++;
      $display("FAIL abort_pending busy=%b ack=%b want 1 0", bus.oBusy, bus.oAck);
    end
    bus.iReq = 1'b0;
    tick();
    checks++;
    if (bus.oBusy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle busy=%b want 0", bus.oBusy);
    end
    vs = 1'b0; exp_frames++;
    tick();
    vs = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      checks++;
      if (bus.oAck !== 1'b0 || o_field !== exp_field || o_score !== exp_score) begin
        errors++;
        $display("FAIL abort_hold cyc=%0d ack=%b score=%0d want ack=0 score=%0d",
                 i, bus.oAck, o_score, exp_score);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_request(rand_field(), $urandom, 2, 10, "b2b_copy_vs");
    run_request(rand_field(), $urandom, 1, 25, "b2b_done_vs");
  endtask

  task automatic test_random();
    int ev;
    for (int k = 0; k < 6; k++) begin
      ev = $urandom_range(0, 2);
      run_request(rand_field(), $urandom, $urandom_range(0, 6),
                  (ev == 0) ? 0 : ((ev == 1) ? 10 : 25), "random");
    end
  endtask

  task automatic test_reset_mid_copy();
    logic [DEF_FIELD_W-1:0] f;
    f = rand_field();
    bus.iReq = 1'b1; bus.iField = f; bus.iScore = $urandom;
    repeat (2) tick();
    vs = 1'b0; exp_frames++;
    for (int m = 1; m <= 11; m++) begin
      if (m == 3) vs = 1'b1;
      tick();
    end
    checks++;
    if (o_field !== merge(exp_field, f, 10)) begin
      errors++;
      $display("FAIL midcopy_rows got %h want %h", o_field, merge(exp_field, f, 10));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_field !== '0 || o_score !== '0 || bus.oAck !== 1'b0 || bus.oBusy !== 1'b0 || o_fc !== '0) begin
      errors++;
      $display("FAIL midcopy_reset score=%0d ack=%b busy=%b fc=%0d want all 0",
               o_score, bus.oAck, bus.oBusy, o_fc);
    end
    exp_field = '0; exp_score = '0; exp_frames = 0;
    bus.iReq = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_request(rand_field(), $urandom, $urandom_range(1, 5), 0, "after_reset");
  endtask

`ifdef FIELD_SCHED_TIMEOUT_EN
  task automatic test_pending_hold();
    logic [DEF_FIELD_W-1:0] f;
    logic [DEF_SCORE_W-1:0] s;
    int ack_t;
    f = rand_field(); s = $urandom;
    bus.iReq = 1'b1; bus.iField = f; bus.iScore = s;
    ack_t = -1;
    for (int t = 1; t <= 1100 && ack_t < 0; t++) begin
      tick();
      if (bus.oAck === 1'b1) ack_t = t;
    end
    checks++;
    if (ack_t != TO_CYC + 21) begin
      errors++;
      $display("FAIL timeout_latency got %0d want %0d", ack_t, TO_CYC + 21);
    end
    checks++;
    if (o_to !== 1'b1 || o_field !== f || o_score !== s) begin
      errors++;
      $display("FAIL timeout_copy to=%b score=%0d want to=1 score=%0d", o_to, o_score, s);
    end
    exp_field = f; exp_score = s;
    bus.iReq = 1'b0;
    tick();
    run_request(rand_field(), $urandom, 3, 0, "post_timeout");
    checks++;
    if (o_to !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky got %b want 1", o_to);
    end
  endtask
`else
  task automatic test_pending_hold();
    bus.iReq = 1'b1; bus.iField = rand_field(); bus.iScore = $urandom;
    for (int t = 1; t <= 1200; t++) begin
      tick();
      if (t % 100 == 0) begin
        checks++;
        if (bus.oBusy !== 1'b1 || bus.oAck !== 1'b0 || o_to !== 1'b0 || o_field !== exp_field) begin
          errors++;
          $display("FAIL pending_hold t=%0d busy=%b ack=%b to=%b want 1 0 0", t, bus.oBusy, bus.oAck, o_to);
        end
      end
    end
    bus.iReq = 1'b0;
    tick();
    checks++;
    if (bus.oBusy !== 1'b0 || o_to !== 1'b0) begin
      errors++;
      $display("FAIL pending_release busy=%b to=%b want 0 0", bus.oBusy, o_to);
    end
  endtask
`endif

  initial begin
    bus.iReq = 1'b0; bus.iField = '0; bus.iScore = '0;
    test_reset();
    test_basic_copy();
    test_same_cycle();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid_copy();
    test_pending_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/field_frame_scheduler.md
Name: field_frame_scheduler

Overview:
- Tear-free handoff of the game field and score from game logic (CPU clocked on the VGA clock) to the VGA pixel path (fieldDisplay).
- The requester presents a new field/score with a four-phase req/ack handshake.
- The block waits for the start of vertical sync, then copies the field one row per cycle into a display-side shadow, latches the score, and acknowledges.
- The display path reads only oField/oScore, so a frame never shows a half-updated board.

Parameters:
- ROWS, 20, field rows
- ROW_W, 20, bits per row
- SCORE_W, 32, score width
- FRAME_CNT_W, 16, frame counter width
- TIMEOUT_CYC, 1000000, watchdog limit in cycles; used only with FIELD_SCHED_TIMEOUT_EN

Ports:
- iVGA_CLK  in  1  pixel clock; only clock
- iRST_n  in  1  asynchronous active-low reset
- iVS  in  1  active-low vsync from video_sync_generator
- iReq  in  1  level request; field/score held stable while high
- iField  in  ROWS*ROW_W  new field; row r = bits [r*ROW_W +: ROW_W]
- iScore  in  SCORE_W  new score
- oAck  out  1  four-phase acknowledge
- oBusy  out  1  high in PENDING or COPY
- oField  out  ROWS*ROW_W  display shadow field
- oScore  out  SCORE_W  display shadow score
- oFrameCnt  out  FRAME_CNT_W  count of vsync starts
- oTimeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, iRST_n=0): state IDLE, row index 0, all outputs 0, vs_d=1.
- Edge detect: vs_d <= iVS every cycle. vs_start = vs_d & ~iVS, combinational, on the registered compare.
- oFrameCnt increments on every vs_start in any state, wraps modulo 2^FRAME_CNT_W.
- States: IDLE, PENDING, COPY, DONE.
- IDLE:
  - iReq=1 and vs_start=1 -> COPY.
  - iReq=1 only -> PENDING.
  - Otherwise stay in IDLE.
- PENDING:
  - iReq=0 -> IDLE. Request aborted; no copy.
  - vs_start=1 -> COPY, row index=0.
- COPY:
  - Each cycle, oField row[idx] <= iField row[idx]; idx increments.
  - At idx=ROWS-1: also oScore <= iScore, then -> DONE.
  - Rows are copied 0..ROWS-1 in order.
  - iReq is ignored in COPY. Dropping it early is a protocol violation, but the copy still completes.
- DONE:
  - oAck=1.
  - Stay while iReq=1. iReq=0 -> IDLE, with oAck low from the next cycle.
  - oAck is high for at least one cycle.
- Latency: vs_start seen at edge N (state enters COPY after edge N). Rows are written at edges N+1..N+ROWS. oAck is high after edge N+ROWS, i.e. 21 cycles for the defaults.
- Copy finishes in 20 cycles, well inside the vertical blanking interval, so the visible field changes only between frames.
- oBusy = (state==PENDING) | (state==COPY).
- oField/oScore change only in COPY. They hold their value otherwise, including across aborts.
- Reset mid-COPY: the shadow clears to all zeros; a partial copy is never retained.
- vs_start while in COPY or DONE: counted in oFrameCnt only; it does not restart the copy.

Optional Feature:
- FIELD_SCHED_TIMEOUT_EN defined:
  - A cycle counter runs in PENDING and clears on leaving PENDING.
  - Reaching TIMEOUT_CYC-1 without vs_start forces -> COPY and sets oTimeout=1.
  - oTimeout is sticky until reset.
  - This covers the case where the sync generator is held in reset.
- FIELD_SCHED_TIMEOUT_EN undefined:
  - No counter; PENDING waits indefinitely.
  - oTimeout is tied to 0.

Decomposition:
- Package field_sched_pkg:
  - state enum (IDLE, PENDING, COPY, DONE)
  - default ROWS, ROW_W, SCORE_W, FRAME_CNT_W
  - FIELD_W = ROWS*ROW_W
  - row-index width = $clog2(ROWS)
- One sub-module, vsync_edge_detect: registers iVS and outputs the vs_start pulse. It is reused by the later score-flash logic.

Test Plan:
- Reset, then idle 2 frames (800x525 timing) -> oField=0, oScore=0, oAck=0, oFrameCnt=2.
- iReq=1 mid-frame, iField=alternating 0xAAAAA rows, iScore=123 -> oBusy=1, no change until vs_start; then rows copied over 20 cycles, oScore=123, and oAck rises exactly 21 cycles after vs_start. Drop iReq -> oAck=0 next cycle, state IDLE.
- iReq rising in the same cycle as vs_start -> copy starts with no wait for the next frame; oAck at +21.
- iReq=1 then dropped before vsync -> back to IDLE, oField unchanged, oAck never asserted.
- Assert iRST_n=0 at row 10 of COPY -> all outputs 0 immediately. After release, a fresh request completes normally.
- With FIELD_SCHED_TIMEOUT_EN and TIMEOUT_CYC=1000, iVS held high, iReq=1 -> COPY after 1000 PENDING cycles, oTimeout=1 and staying 1 through later requests. Without the macro, PENDING persists and oTimeout=0.
